// File: rtl/data_obi_arb2_if.sv
// data_obi_arb2_if: one OBI data port (request, grant and response channels).
// The master modport drives the request; the slave modport answers it.
interface data_obi_arb2_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [32:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [32:0] rdata;
    logic        err;
    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/data_obi_arb2.sv
// data_obi_arb2: round-robin two-master arbiter onto one OBI data port.
// An in-order owner FIFO steers each response back to the master that issued it.
module data_obi_arb2 #(
    parameter int MAX_OUTST = 4,
    parameter bit RR_EN     = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    data_obi_arb2_if.slave                 m0,
    data_obi_arb2_if.slave                 m1,
    data_obi_arb2_if.master                s,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           unexp_rsp
);
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;

    logic [MAX_OUTST-1:0] r_fifo;
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [CW-1:0]        r_cnt;
    logic                 r_hold_vld, r_hold_id, r_rr_last, r_unexp;
    logic                 w_sel, w_sel_req, w_full, w_empty, w_hs, w_pop, w_head;

    // A held request keeps its master selected until granted; ties alternate.
    assign w_sel = r_hold_vld ? r_hold_id :
                   (m0.req ^ m1.req) ? m1.req :
                   (m0.req & m1.req) ? (RR_EN ? ~r_rr_last : 1'b0) : r_rr_last;
    assign w_sel_req = w_sel ? m1.req : m0.req;
    assign w_full    = r_cnt == CW'(MAX_OUTST);
    assign w_empty   = r_cnt == '0;
    assign w_hs      = s.req & s.gnt;
    assign w_pop     = s.rvalid & ~w_empty;
    assign w_head    = r_fifo[r_rptr];

    assign s.req   = w_sel_req & ~w_full;
    assign s.we    = w_sel ? m1.we    : m0.we;
    assign s.be    = w_sel ? m1.be    : m0.be;
    assign s.addr  = w_sel ? m1.addr  : m0.addr;
    assign s.wdata = w_sel ? m1.wdata : m0.wdata;

    assign m0.gnt    = w_hs & ~w_sel;
    assign m1.gnt    = w_hs & w_sel;
    assign m0.rvalid = w_pop & ~w_head;
    assign m1.rvalid = w_pop & w_head;
    assign m0.rdata  = m0.rvalid ? s.rdata : '0;
    assign m1.rdata  = m1.rvalid ? s.rdata : '0;
    assign m0.err    = m0.rvalid & s.err;
    assign m1.err    = m1.rvalid & s.err;

    assign outst_cnt = r_cnt;
    assign unexp_rsp = r_unexp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_hold_vld <= 1'b0;
            r_hold_id  <= 1'b0;
            r_rr_last  <= 1'b1;
            r_unexp    <= 1'b0;
        end else begin
            if (w_hs) begin
                r_fifo[r_wptr] <= w_sel;
                r_wptr         <= r_wptr == PW'(MAX_OUTST - 1) ? '0 : r_wptr + PW'(1);
                r_rr_last      <= w_sel;
            end
            if (w_pop)
                r_rptr <= r_rptr == PW'(MAX_OUTST - 1) ? '0 : r_rptr + PW'(1);
            r_cnt      <= r_cnt + CW'(w_hs) - CW'(w_pop);
            r_hold_vld <= s.req & ~s.gnt;
            if (s.req & ~s.gnt)
                r_hold_id <= w_sel;
            r_unexp    <= r_unexp | (s.rvalid & w_empty);
        end
    end
endmodule

// File: tb/tb_data_obi_arb2.sv
// tb_data_obi_arb2: directed checks of data_obi_arb2 with MAX_OUTST = 4, RR_EN = 1.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_data_obi_arb2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] cnt_w;
    logic       unexp_w;
    int         n_cmp = 0;
    int         n_err = 0;

    data_obi_arb2_if m0_if ();
    data_obi_arb2_if m1_if ();
    data_obi_arb2_if s_if ();

    data_obi_arb2 #(.MAX_OUTST(4), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if), .s(s_if),
        .outst_cnt(cnt_w), .unexp_rsp(unexp_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic pulse_rst;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m0_if.req = 0; m0_if.we = 0; m0_if.be = 4'hf; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.req = 0; m1_if.we = 0; m1_if.be = 4'hf; m1_if.addr = 0; m1_if.wdata = 0;
        s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = 0; s_if.err = 0;
        #1;
        chk("rst_cnt", 64'(cnt_w), 0);
        chk("rst_unexp", 64'(unexp_w), 0);
        chk("rst_sreq", 64'(s_if.req), 0);
        chk("rst_m0gnt", 64'(m0_if.gnt), 0);
        chk("rst_m1rvalid", 64'(m1_if.rvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single m0 read, answered two cycles after the grant
        @(negedge clk);
        m0_if.req = 1; m0_if.addr = 32'h8000_0010; s_if.gnt = 1;
        #1;
        chk("t1_sreq", 64'(s_if.req), 1);
        chk("t1_saddr", 64'(s_if.addr), 64'h8000_0010);
        chk("t1_m0gnt", 64'(m0_if.gnt), 1);
        chk("t1_m1gnt", 64'(m1_if.gnt), 0);
        @(negedge clk);
        m0_if.req = 0; s_if.gnt = 0;
        #1;
        chk("t1_cnt1", 64'(cnt_w), 1);
        @(negedge clk);
        s_if.rvalid = 1; s_if.rdata = 33'h1_1234_5678;
        #1;
        chk("t1_m0rvalid", 64'(m0_if.rvalid), 1);
        chk("t1_m0rdata", 64'(m0_if.rdata), 64'h1_1234_5678);
        chk("t1_m1rvalid", 64'(m1_if.rvalid), 0);
        chk("t1_m1rdata", 64'(m1_if.rdata), 0);
        @(negedge clk);
        s_if.rvalid = 0; s_if.rdata = 0;
        #1;
        chk("t1_cnt0", 64'(cnt_w), 0);
        chk("t1_unexp", 64'(unexp_w), 0);

        // both request every cycle: m0, m1, m0, m1, then the FIFO is full
        pulse_rst();
        @(negedge clk);
        m0_if.req = 1; m0_if.addr = 32'h100; m1_if.req = 1; m1_if.addr = 32'h200; s_if.gnt = 1;
        #1;
        chk("t2_g0_m0", 64'(m0_if.gnt), 1);
        chk("t2_g0_m1", 64'(m1_if.gnt), 0);
        chk("t2_g0_addr", 64'(s_if.addr), 64'h100);
        @(negedge clk);
        #1;
        chk("t2_g1_m1", 64'(m1_if.gnt), 1);
        chk("t2_g1_m0", 64'(m0_if.gnt), 0);
        chk("t2_g1_addr", 64'(s_if.addr), 64'h200);
        @(negedge clk);
        #1;
        chk("t2_g2_m0", 64'(m0_if.gnt), 1);
        @(negedge clk);
        #1;
        chk("t2_g3_m1", 64'(m1_if.gnt), 1);
        chk("t2_cnt3", 64'(cnt_w), 3);
        @(negedge clk);
        s_if.rvalid = 1; s_if.rdata = 33'h0_aaaa_0000;
        #1;
        chk("t4_full_cnt", 64'(cnt_w), 4);
        chk("t4_full_sreq", 64'(s_if.req), 0);
        chk("t4_full_m0gnt", 64'(m0_if.gnt), 0);
        chk("t4_full_m1gnt", 64'(m1_if.gnt), 0);
        chk("t4_rsp0_m0", 64'(m0_if.rvalid), 1);
        chk("t4_rsp0_m1", 64'(m1_if.rvalid), 0);
        chk("t4_rsp0_data", 64'(m0_if.rdata), 64'h0_aaaa_0000);
        @(negedge clk);
        s_if.rdata = 33'h1_bbbb_0001;
        #1;
        chk("t4_cnt3", 64'(cnt_w), 3);
        chk("t4_sreq_back", 64'(s_if.req), 1);
        chk("t4_m0gnt", 64'(m0_if.gnt), 1);
        chk("t4_rsp1_m1", 64'(m1_if.rvalid), 1);
        chk("t4_rsp1_data", 64'(m1_if.rdata), 64'h1_bbbb_0001);
        chk("t4_rsp1_m0", 64'(m0_if.rvalid), 0);
        @(negedge clk);
        m0_if.req = 0; m1_if.req = 0; s_if.gnt = 0; s_if.rdata = 33'h0_0000_00c0;
        #1;
        chk("t4_pushpop_cnt", 64'(cnt_w), 3);
        chk("t5_rsp2_m0", 64'(m0_if.rvalid), 1);
        @(negedge clk);
        s_if.err = 1; s_if.rdata = 33'h0_dead_beef;
        #1;
        chk("t5_err_m1rvalid", 64'(m1_if.rvalid), 1);
        chk("t5_err_m1err", 64'(m1_if.err), 1);
        chk("t5_err_m0rvalid", 64'(m0_if.rvalid), 0);
        chk("t5_err_m0err", 64'(m0_if.err), 0);
        @(negedge clk);
        s_if.err = 0; s_if.rdata = 33'h1_0000_0042;
        #1;
        chk("t5_last_m0", 64'(m0_if.rvalid), 1);
        chk("t5_last_data", 64'(m0_if.rdata), 64'h1_0000_0042);
        @(negedge clk);
        s_if.rvalid = 0; s_if.rdata = 0;
        #1;
        chk("t5_drained", 64'(cnt_w), 0);
        chk("t5_no_unexp", 64'(unexp_w), 0);

        // m1 stalled without grant keeps the port even when m0 joins a tie it would win
        pulse_rst();
        @(negedge clk);
        m1_if.req = 1; m1_if.addr = 32'h300;
        #1;
        chk("t3_c1_sreq", 64'(s_if.req), 1);
        chk("t3_c1_addr", 64'(s_if.addr), 64'h300);
        chk("t3_c1_m1gnt", 64'(m1_if.gnt), 0);
        @(negedge clk);
        #1;
        chk("t3_c2_addr", 64'(s_if.addr), 64'h300);
        @(negedge clk);
        m0_if.req = 1; m0_if.addr = 32'h100;
        #1;
        chk("t3_c3_addr", 64'(s_if.addr), 64'h300);
        chk("t3_c3_m0gnt", 64'(m0_if.gnt), 0);
        @(negedge clk);
        s_if.gnt = 1;
        #1;
        chk("t3_c4_addr", 64'(s_if.addr), 64'h300);
        chk("t3_c4_m1gnt", 64'(m1_if.gnt), 1);
        chk("t3_c4_m0gnt", 64'(m0_if.gnt), 0);
        @(negedge clk);
        m1_if.req = 0;
        #1;
        chk("t3_c5_m0gnt", 64'(m0_if.gnt), 1);
        chk("t3_c5_addr", 64'(s_if.addr), 64'h100);
        @(negedge clk);
        m0_if.req = 0; s_if.gnt = 0;
        #1;
        chk("t6_cnt2", 64'(cnt_w), 2);

        // asynchronous reset with two outstanding, then a stray response
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("t6_async_cnt", 64'(cnt_w), 0);
        rst_n = 1;
        @(negedge clk);
        s_if.rvalid = 1; s_if.rdata = 33'h1_5555_5555;
        #1;
        chk("t6_stray_m0", 64'(m0_if.rvalid), 0);
        chk("t6_stray_m1", 64'(m1_if.rvalid), 0);
        chk("t6_stray_m0data", 64'(m0_if.rdata), 0);
        @(negedge clk);
        s_if.rvalid = 0; s_if.rdata = 0;
        #1;
        chk("t6_unexp_set", 64'(unexp_w), 1);
        chk("t6_cnt_stays0", 64'(cnt_w), 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_unexp_sticky", 64'(unexp_w), 1);
        rst_n = 0;
        #1;
        chk("t6_unexp_clr", 64'(unexp_w), 0);
        rst_n = 1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
